// File: rtl/hs_mem_sdpram_pipe.sv
// hs_mem_sdpram_pipe
//   Single-clock simple dual-port RAM (one write port, one read port) with a
//   parameterised read latency and a read-valid flag. After reset an init FSM
//   walks every storage entry and writes zero. The user ports are ignored
//   until that walk completes.
//
// Parameters
//   DATA_TYPE   item type stored in the RAM
//   DATA_DEPTH  logical depth (1..1048576); storage is rounded up to a power of two
//   RD_LATENCY  ren-to-rdata latency in clock cycles (1..4)
//   ADDR_WIDTH  derived address width (not overridable)
//
// Ports
//   clk        single clock for all logic
//   rst_n      synchronous active-low reset
//   waddr      write address
//   wdata      write data
//   wen        write enable
//   raddr      read address
//   ren        read enable
//   rdata      read data; holds the last valid result while rvalid is low
//   rvalid     rdata carries the result of an accepted read (one cycle per read)
//   init_done  RAM cleared, ports accept traffic
//
// Build option
//   HS_MEM_SDPRAM_PIPE_FWD_EN  defined: same-cycle write-to-read forwarding on an
//                              address collision. Undefined: read-first.

module hs_mem_sdpram_pipe #(
    parameter type         DATA_TYPE  = logic [7:0],
    parameter int unsigned DATA_DEPTH = 16,
    parameter int unsigned RD_LATENCY = 1,
    localparam int unsigned ADDR_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  DATA_TYPE              wdata,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  ren,
    output DATA_TYPE              rdata,
    output logic                  rvalid,
    output logic                  init_done
);

    localparam int unsigned DEPTH_REAL = 1 << $clog2(DATA_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH_REAL - 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("hs_mem_sdpram_pipe: RD_LATENCY must be in 1..4");
    end
    if (DATA_DEPTH < 1 || DATA_DEPTH > 1048576) begin : g_bad_depth
        $error("hs_mem_sdpram_pipe: DATA_DEPTH must be in 1..1048576");
    end

    typedef enum logic {StInit, StReady} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clr_we;
    logic                  wr_acc;
    logic                  rd_acc;
    DATA_TYPE              rd_word;

    DATA_TYPE              ram [DEPTH_REAL];

    DATA_TYPE              pipe_data [RD_LATENCY];
    logic [RD_LATENCY-1:0] pipe_valid;

    // Init FSM: one zero write per cycle; the counter parks on the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            StInit: begin
                clr_we = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = StReady;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_done = (state_q == StReady);
    assign wr_acc    = wen & init_done;
    assign rd_acc    = ren & init_done;

    // Storage has no reset so it can map onto plain block RAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            ram[cnt_q] <= '0;
        end else if (wr_acc) begin
            ram[waddr] <= wdata;
        end
    end

`ifdef HS_MEM_SDPRAM_PIPE_FWD_EN
    assign rd_word = (wr_acc && (waddr == raddr)) ? wdata : ram[raddr];
`else
    assign rd_word = ram[raddr];
`endif

    // Stage 0 is the RAM output register; later stages only load on a valid
    // so the output holds the last result between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_acc;
            if (rd_acc) begin
                pipe_data[0] <= rd_word;
            end
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign rdata  = pipe_data[RD_LATENCY-1];
    assign rvalid = pipe_valid[RD_LATENCY-1];

endmodule

// File: tb/tb_hs_mem_sdpram_pipe.sv
// tb_hs_mem_sdpram_pipe
//   Four instances share one stimulus stream: depth 16 with latencies 1, 3, 4
//   and depth 12 (16 real entries) with latency 2. Each cycle every instance
//   is compared against a history-based reference: the value each accepted
//   read returns is logged by clock edge, and the expected output of an
//   instance is looked up from that log using its latency.

module tb_hs_mem_sdpram_pipe;

    localparam int NI   = 4;
    localparam int MAXE = 4000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] waddr, raddr;
    logic [7:0] wdata;
    logic       wen, ren;

    logic [7:0] rd0, rd1, rd2, rd3;
    logic       rv0, rv1, rv2, rv3;
    logic       id0, id1, id2, id3;

    always #5 clk = ~clk;

    hs_mem_sdpram_pipe #(.DATA_TYPE(logic [7:0]), .DATA_DEPTH(16), .RD_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .wen(wen),
        .raddr(raddr), .ren(ren), .rdata(rd0), .rvalid(rv0), .init_done(id0)
    );
    hs_mem_sdpram_pipe #(.DATA_TYPE(logic [7:0]), .DATA_DEPTH(12), .RD_LATENCY(2)) u_d12 (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .wen(wen),
        .raddr(raddr), .ren(ren), .rdata(rd1), .rvalid(rv1), .init_done(id1)
    );
    hs_mem_sdpram_pipe #(.DATA_TYPE(logic [7:0]), .DATA_DEPTH(16), .RD_LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .wen(wen),
        .raddr(raddr), .ren(ren), .rdata(rd2), .rvalid(rv2), .init_done(id2)
    );
    hs_mem_sdpram_pipe #(.DATA_TYPE(logic [7:0]), .DATA_DEPTH(16), .RD_LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .wen(wen),
        .raddr(raddr), .ren(ren), .rdata(rd3), .rvalid(rv3), .init_done(id3)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    int         lat [NI] = '{1, 2, 3, 4};
    int         ecount   = 0;     // index of the next clock edge
    int         last_rst = 0;     // edge index of the latest reset edge
    bit         hv [MAXE];        // a read was accepted at this edge
    logic [7:0] hd [MAXE];        // value that read returns
    logic [7:0] mem [16];

    typedef struct {
        logic       wen;
        logic [3:0] waddr;
        logic [7:0] wdata;
        logic       ren;
        logic [3:0] raddr;
        logic       exp_rv;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d edge %0d got %0h expected %0h",
                     name, inst, ecount - 1, got, exp);
        end
    endtask

    task automatic model_check(input int e);
        int         k;
        logic       ev;
        logic [7:0] ed;
        logic       g_rv, g_id;
        logic [7:0] g_rd;
        for (int i = 0; i < NI; i++) begin
            k  = e - lat[i] + 1;
            ev = (k > last_rst) && hv[k];
            ed = 8'h00;
            for (int j = k; j > last_rst; j--) begin
                if (hv[j]) begin
                    ed = hd[j];
                    break;
                end
            end
            case (i)
                0:       begin g_rv = rv0; g_rd = rd0; g_id = id0; end
                1:       begin g_rv = rv1; g_rd = rd1; g_id = id1; end
                2:       begin g_rv = rv2; g_rd = rd2; g_id = id2; end
                default: begin g_rv = rv3; g_rd = rd3; g_id = id3; end
            endcase
            chk("model_rvalid", i, 32'(g_rv), 32'(ev));
            chk("model_rdata", i, 32'(g_rd), 32'(ed));
            chk("model_init_done", i, 32'(g_id), 32'((e - last_rst) >= 16));
        end
    endtask

    // Advance one edge: update the reference with the inputs sampled at that
    // edge, then compare all instances 1 time unit later.
    task automatic tick();
        int         e;
        bit         done;
        logic [7:0] d;
        @(posedge clk);
        e = ecount;
        if (e >= MAXE) begin
            $display("FAIL edge_budget inst0 edge %0d got %0d expected %0d", e, e, MAXE - 1);
            $fatal(1, "edge budget exhausted");
        end
        if (!rst_n) begin
            last_rst = e;
            hv[e]    = 1'b0;
            hd[e]    = 8'h00;
            for (int a = 0; a < 16; a++) mem[a] = 8'h00;
        end else begin
            done  = (e - 1 - last_rst) >= 16;
            hv[e] = ren && done;
            d     = mem[raddr];
`ifdef HS_MEM_SDPRAM_PIPE_FWD_EN
            if (wen && done && (waddr == raddr)) d = wdata;
`endif
            hd[e] = d;
            if (wen && done) mem[waddr] = wdata;
        end
        ecount++;
        #1;
        model_check(e);
    endtask

    initial begin
        int         n;
        int         f;
        int         e;
        logic [7:0] fwd_22_11, fwd_ff_00;
`ifdef HS_MEM_SDPRAM_PIPE_FWD_EN
        fwd_22_11 = 8'h22;
        fwd_ff_00 = 8'hFF;
`else
        fwd_22_11 = 8'h11;
        fwd_ff_00 = 8'h00;
`endif
        //            wen   waddr  wdata  ren   raddr  exp_rv exp_rd (latency-1 instance)
        tbl[0]  = '{1'b1, 4'd5,  8'hA5, 1'b0, 4'd0,  1'b0, 8'h00};
        tbl[1]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd5,  1'b1, 8'hA5};
        tbl[2]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b0, 8'hA5};
        tbl[3]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b0, 8'hA5};
        tbl[4]  = '{1'b1, 4'd7,  8'h11, 1'b0, 4'd0,  1'b0, 8'hA5};
        tbl[5]  = '{1'b1, 4'd7,  8'h22, 1'b1, 4'd7,  1'b1, fwd_22_11};
        tbl[6]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd7,  1'b1, 8'h22};
        tbl[7]  = '{1'b1, 4'd14, 8'h5C, 1'b0, 4'd0,  1'b0, 8'h22};
        tbl[8]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd14, 1'b1, 8'h5C};
        tbl[9]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 1'b1, 8'h00};
        tbl[10] = '{1'b1, 4'd0,  8'hFF, 1'b1, 4'd0,  1'b1, fwd_ff_00};
        tbl[11] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd0,  1'b1, 8'hFF};
        tbl[12] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b0, 8'hFF};

        rst_n = 1'b0; wen = 1'b0; ren = 1'b0; waddr = '0; raddr = '0; wdata = '0;

        // Reset for 3 edges, then init with traffic that must be ignored.
        repeat (3) tick();
        chk("reset_rvalid", 0, 32'(rv0), 32'd0);
        chk("reset_init_done", 0, 32'(id0), 32'd0);
        rst_n = 1'b1;
        wen = 1'b1; waddr = 4'd3; wdata = 8'h77; ren = 1'b1; raddr = 4'd3;
        n = 0;
        while (!id0 && n < 40) begin
            tick();
            n++;
            if (!id0) chk("init_no_rvalid", 0, 32'(rv0), 32'd0);
        end
        chk("init_cycles", 0, 32'(n), 32'd16);
        chk("init_cycles_d12", 1, 32'(id1), 32'd1);

        // Back-to-back reads of every address, first one on the rise cycle.
        wen = 1'b0;
        f   = ecount;
        for (int c = 0; c < 20; c++) begin
            ren   = (c < 16);
            raddr = 4'(c);
            tick();
            e = ecount - 1;
            chk("b2b_rvalid_l3", 2, 32'(rv2), 32'((e >= f + 2) && (e < f + 18)));
            if (rv2) chk("b2b_rdata_l3", 2, 32'(rd2), 32'd0);
        end

        // Directed vectors with explicit expectations for the latency-1 instance.
        for (int i = 0; i < 13; i++) begin
            wen = tbl[i].wen; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
            ren = tbl[i].ren; raddr = tbl[i].raddr;
            tick();
            chk("vec_rvalid", 0, 32'(rv0), 32'(tbl[i].exp_rv));
            chk("vec_rdata", 0, 32'(rd0), 32'(tbl[i].exp_rd));
        end
        wen = 1'b0; ren = 1'b0;
        repeat (4) tick();

        // Reset with two latency-4 reads in flight.
        ren = 1'b1; raddr = 4'd5;
        repeat (2) begin
            tick();
            chk("flush_rvalid_l4", 3, 32'(rv3), 32'd0);
        end
        rst_n = 1'b0;
        repeat (2) begin
            tick();
            chk("flush_rvalid_l4", 3, 32'(rv3), 32'd0);
            chk("flush_init_done", 3, 32'(id3), 32'd0);
        end
        rst_n = 1'b1; ren = 1'b0;
        n = 0;
        while (!id0 && n < 40) begin
            tick();
            n++;
            chk("flush_rvalid_l4", 3, 32'(rv3), 32'd0);
        end
        chk("reinit_cycles", 0, 32'(n), 32'd16);
        ren = 1'b1; raddr = 4'd5;
        tick();
        ren = 1'b0;
        chk("reinit_rvalid", 0, 32'(rv0), 32'd1);
        chk("reinit_rdata", 0, 32'(rd0), 32'd0);
        repeat (4) tick();

        // Random traffic with occasional resets and frequent collisions.
        for (int c = 0; c < 800; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            wen   = 1'($urandom_range(0, 1));
            ren   = 1'($urandom_range(0, 1));
            waddr = 4'($urandom_range(0, 15));
            wdata = 8'($urandom_range(0, 255));
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            tick();
        end
        rst_n = 1'b1; wen = 1'b0; ren = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
